// File: rtl/shift_pkg.sv
// Shared mode encoding and mode classification helpers for the pipelined shifter.
package shift_pkg;

  typedef enum logic [2:0] {
    SHIFT_SLL = 3'd0,
    SHIFT_SRL = 3'd1,
    SHIFT_SRA = 3'd2,
    SHIFT_ROL = 3'd3,
    SHIFT_ROR = 3'd4
  } shift_mode_t;

  function automatic logic mode_is_right(input logic [2:0] mode);
    return (mode == SHIFT_SRL) || (mode == SHIFT_SRA) || (mode == SHIFT_ROR);
  endfunction

  function automatic logic mode_is_rot(input logic [2:0] mode);
    return (mode == SHIFT_ROL) || (mode == SHIFT_ROR);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage: a run of power-of-two mux levels followed by a register
// that carries data, mode, shift amount, fill bit and tag forward.
module shift_stage
  import shift_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int FIRST_LEVEL = 0,
  parameter int NUM_LEVELS  = 1,
  parameter int TAG_WIDTH   = 4,
  localparam int SHW = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  src_valid,
  input  logic [2:0]            src_mode,
  input  logic [SHW-1:0]        src_shift,
  input  logic                  src_fill,
  input  logic [DATA_WIDTH-1:0] src_data,
  input  logic [TAG_WIDTH-1:0]  src_tag,
  input  logic                  dst_adv,
  output logic                  valid,
  output logic [2:0]            mode,
  output logic [SHW-1:0]        shift,
  output logic                  fill,
  output logic [DATA_WIDTH-1:0] data,
  output logic [TAG_WIDTH-1:0]  tag,
  output logic                  adv
);

  logic [DATA_WIDTH-1:0] shifted;

  // Shift by one fixed power of two; the SRA fill is the original operand MSB,
  // so chaining levels composes into the full arithmetic shift.
  function automatic logic [DATA_WIDTH-1:0] shift_level(
    input logic [DATA_WIDTH-1:0] x,
    input logic [2:0]            m,
    input logic                  f,
    input int unsigned           amt
  );
    logic [DATA_WIDTH-1:0] r;
    if (m > SHIFT_ROR) begin
      r = x;
    end else if (mode_is_right(m)) begin
      r = x >> amt;
      if (mode_is_rot(m))
        r |= x << (DATA_WIDTH - amt);
      else if (m == SHIFT_SRA && f)
        r |= ~({DATA_WIDTH{1'b1}} >> amt);
    end else begin
      r = x << amt;
      if (mode_is_rot(m))
        r |= x >> (DATA_WIDTH - amt);
    end
    return r;
  endfunction

  // NOTE: the unconditional default first keeps this block free of latches.
  always_comb begin
    shifted = src_data;
    for (int l = 0; l < NUM_LEVELS; l++) begin
      if (src_shift[FIRST_LEVEL + l])
        shifted = shift_level(shifted, src_mode, src_fill, 1 << (FIRST_LEVEL + l));
    end
  end

  assign adv = !valid || dst_adv;

  // NOTE: payload registers are reset too, so the output word reads 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      mode  <= '0;
      shift <= '0;
      fill  <= 1'b0;
      data  <= '0;
      tag   <= '0;
    end else begin
      if (flush)
        valid <= 1'b0;
      else if (adv)
        valid <= src_valid;
      if (adv && src_valid) begin
        mode  <= src_mode;
        shift <= src_shift;
        fill  <= src_fill;
        data  <= shifted;
        tag   <= src_tag;
      end
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Parametrised pipelined barrel shifter/rotator with valid/ready flow control,
// flush and a pass-through sideband tag.
module shift_pipe
  import shift_pkg::*;
#(
  parameter int DATA_WIDTH       = 64,
  parameter int LEVELS_PER_STAGE = 2,
  parameter int TAG_WIDTH        = 4,
  localparam int SHW    = $clog2(DATA_WIDTH),
  localparam int NSTAGE = (SHW + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [2:0]            mode_i,
  input  logic [SHW-1:0]        shift_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [TAG_WIDTH-1:0]  tag_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [TAG_WIDTH-1:0]  tag_o
);

  // Index 0 is the input side; index s+1 is the register of stage s.
  logic [NSTAGE:0]       v_c;
  logic [2:0]            mode_c  [NSTAGE+1];
  logic [SHW-1:0]        shift_c [NSTAGE+1];
  logic                  fill_c  [NSTAGE+1];
  logic [DATA_WIDTH-1:0] data_c  [NSTAGE+1];
  logic [TAG_WIDTH-1:0]  tag_c   [NSTAGE+1];
  logic                  adv_c     [NSTAGE];
  logic                  dst_adv_c [NSTAGE];

  assign v_c[0]     = in_valid_i && !flush_i;
  assign mode_c[0]  = mode_i;
  assign shift_c[0] = shift_i;
  assign fill_c[0]  = data_i[DATA_WIDTH-1];
  assign data_c[0]  = data_i;
  assign tag_c[0]   = tag_i;

  for (genvar s = 0; s < NSTAGE; s++) begin : g_stage
    localparam int FIRST = s * LEVELS_PER_STAGE;
    localparam int NUM   = (SHW - FIRST < LEVELS_PER_STAGE) ? SHW - FIRST : LEVELS_PER_STAGE;

    // Downstream advances when out_ready_i is high or any later stage has a hole;
    // written flat over the valid bits to avoid a self-referencing ripple net.
    assign dst_adv_c[s] = out_ready_i || !(&v_c[NSTAGE:s+1]);

    shift_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIRST_LEVEL(FIRST),
      .NUM_LEVELS (NUM),
      .TAG_WIDTH  (TAG_WIDTH)
    ) u_stage (
      .clk      (clk_i),
      .rst      (rst_i),
      .flush    (flush_i),
      .src_valid(v_c[s]),
      .src_mode (mode_c[s]),
      .src_shift(shift_c[s]),
      .src_fill (fill_c[s]),
      .src_data (data_c[s]),
      .src_tag  (tag_c[s]),
      .dst_adv  (dst_adv_c[s]),
      .valid    (v_c[s+1]),
      .mode     (mode_c[s+1]),
      .shift    (shift_c[s+1]),
      .fill     (fill_c[s+1]),
      .data     (data_c[s+1]),
      .tag      (tag_c[s+1]),
      .adv      (adv_c[s])
    );
  end

  assign in_ready_o  = adv_c[0] && !flush_i;
  assign out_valid_o = v_c[NSTAGE];
  assign data_o      = data_c[NSTAGE];
  assign tag_o       = tag_c[NSTAGE];

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench: directed and randomized traffic against a plain-arithmetic
// shift model, plus an exhaustive sweep of an 8-bit single-stage instance.
module tb_shift_pipe;

  typedef struct {
    logic [63:0] d;
    logic [3:0]  t;
  } item_t;

  logic        clk;
  logic        rst_i, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [2:0]  mode_i;
  logic [5:0]  shift_i;
  logic [63:0] data_i, data_o;
  logic [3:0]  tag_i, tag_o;

  logic        flush8, in_valid8, in_ready8, out_valid8, out_ready8;
  logic [2:0]  mode8, shift8;
  logic [7:0]  data8, dout8;
  logic [3:0]  tag8, tout8;

  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;
  int    n_acc    = 0;
  int    n_cons   = 0;
  int    first_cons, last_cons;
  item_t exp_q[$];
  logic [7:0] q8[$];

  shift_pipe #(.DATA_WIDTH(64), .LEVELS_PER_STAGE(2), .TAG_WIDTH(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .mode_i(mode_i), .shift_i(shift_i), .data_i(data_i), .tag_i(tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .data_o(data_o), .tag_o(tag_o)
  );

  shift_pipe #(.DATA_WIDTH(8), .LEVELS_PER_STAGE(3), .TAG_WIDTH(4)) dut8 (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush8),
    .in_valid_i(in_valid8), .in_ready_o(in_ready8),
    .mode_i(mode8), .shift_i(shift8), .data_i(data8), .tag_i(tag8),
    .out_valid_o(out_valid8), .out_ready_i(out_ready8),
    .data_o(dout8), .tag_o(tout8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Reference: shift/rotate of a w-bit word computed with whole-word arithmetic.
  function automatic logic [63:0] ref_shift(input int w, input logic [2:0] m,
                                            input int sh, input logic [63:0] x_in);
    logic [63:0]        mask, x, sx;
    logic signed [63:0] ss;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    x    = x_in & mask;
    sx   = x[w-1] ? (x | ~mask) : x;
    ss   = $signed(sx) >>> sh;
    case (m)
      3'd0:    return (x << sh) & mask;
      3'd1:    return x >> sh;
      3'd2:    return ss & mask;
      3'd3:    return ((x << sh) | (x >> (w - sh))) & mask;
      3'd4:    return ((x >> sh) | (x << (w - sh))) & mask;
      default: return x;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One clock of the 64-bit instance: called at a negedge with inputs already set.
  task automatic tick();
    item_t it, got;
    #1;
    if (out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", {63'd0, out_valid_o}, 64'd0);
      end else begin
        got = exp_q.pop_front();
        check("sb_data", data_o, got.d);
        check("sb_tag", {60'd0, tag_o}, {60'd0, got.t});
      end
      n_cons++;
      if (first_cons < 0) first_cons = cyc;
      last_cons = cyc;
    end
    if (in_valid_i && in_ready_o) begin
      it.d = ref_shift(64, mode_i, int'(shift_i), data_i);
      it.t = tag_i;
      exp_q.push_back(it);
      n_acc++;
    end
    if (rst_i || flush_i) exp_q.delete();
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_idle();
    in_valid_i = 1'b0;
    mode_i     = 'x;
    shift_i    = 'x;
    data_i     = 'x;
    tag_i      = 'x;
  endtask

  task automatic set_item(input logic [2:0] m, input logic [5:0] sh,
                          input logic [63:0] d, input logic [3:0] t);
    in_valid_i = 1'b1;
    mode_i     = m;
    shift_i    = sh;
    data_i     = d;
    tag_i      = t;
  endtask

  task automatic set_random(input logic [3:0] t);
    set_item(3'($urandom_range(0, 7)), 6'($urandom_range(0, 63)), {$urandom, $urandom}, t);
  endtask

  // Single item through an empty pipe: latency, result and tag against constants.
  task automatic run_one(input string name, input logic [2:0] m, input logic [5:0] sh,
                         input logic [63:0] d, input logic [3:0] t, input logic [63:0] exp_d);
    int lat;
    out_ready_i = 1'b1;
    set_item(m, sh, d, t);
    #1 check({name, "_ready"}, {63'd0, in_ready_o}, 64'd1);
    tick();
    set_idle();
    lat = 1;
    while (!out_valid_o && lat < 20) begin
      @(negedge clk);
      cyc++;
      lat++;
    end
    check({name, "_lat"}, 64'(lat), 64'd3);
    check({name, "_data"}, data_o, exp_d);
    check({name, "_tag"}, {60'd0, tag_o}, {60'd0, t});
    tick();
  endtask

  initial begin
    logic [63:0] hold_d;
    logic [3:0]  hold_t;
    logic        have_hold;
    int          acc0, cons0;
    logic [63:0] r64;
    logic [7:0]  r8;

    first_cons  = -1;
    last_cons   = -1;
    rst_i       = 1'b1;
    flush_i     = 1'b0;
    out_ready_i = 1'b0;
    set_idle();
    flush8      = 1'b0;
    in_valid8   = 1'b0;
    out_ready8  = 1'b1;
    mode8       = 'x;
    shift8      = 'x;
    data8       = 'x;
    tag8        = 'x;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    #1;
    check("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
    check("rst_data", data_o, 64'd0);
    check("rst_tag", {60'd0, tag_o}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready_o}, 64'd1);
    @(negedge clk);

    run_one("sll63", 3'd0, 6'd63, 64'h0000_0000_0000_0001, 4'h5, 64'h8000_0000_0000_0000);
    run_one("sra4",  3'd2, 6'd4,  64'h8000_0000_0000_00F0, 4'h6, 64'hF800_0000_0000_000F);
    run_one("srl4",  3'd1, 6'd4,  64'h8000_0000_0000_00F0, 4'h7, 64'h0800_0000_0000_000F);
    run_one("rol1",  3'd3, 6'd1,  64'h8000_0000_0000_0001, 4'h8, 64'h0000_0000_0000_0003);
    run_one("ror1",  3'd4, 6'd1,  64'h8000_0000_0000_0001, 4'h9, 64'hC000_0000_0000_0000);
    run_one("mode6", 3'd6, 6'd13, 64'h0123_4567_89AB_CDEF, 4'hA, 64'h0123_4567_89AB_CDEF);
    run_one("shift0", 3'd2, 6'd0, 64'h8765_4321_0FED_CBA9, 4'hB, 64'h8765_4321_0FED_CBA9);

    // Back-to-back stream of random items.
    first_cons  = -1;
    cons0       = n_cons;
    out_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_random(4'(i));
      tick();
    end
    set_idle();
    repeat (6) tick();
    check("stream_count", 64'(n_cons - cons0), 64'd10);
    check("stream_back2back", 64'(last_cons - first_cons), 64'd9);

    // Backpressure: the pipe fills to three items, stalls, then drains in order.
    out_ready_i = 1'b0;
    acc0        = n_acc;
    cons0       = n_cons;
    have_hold   = 1'b0;
    hold_d      = '0;
    hold_t      = '0;
    for (int i = 0; i < 5; i++) begin
      set_random(4'(10 + i));
      tick();
      if (out_valid_o) begin
        if (!have_hold) begin
          hold_d    = data_o;
          hold_t    = tag_o;
          have_hold = 1'b1;
        end else begin
          check("stall_data", data_o, hold_d);
          check("stall_tag", {60'd0, tag_o}, {60'd0, hold_t});
        end
      end
    end
    #1;
    check("stall_accepted", 64'(n_acc - acc0), 64'd3);
    check("stall_in_ready", {63'd0, in_ready_o}, 64'd0);
    set_idle();
    out_ready_i = 1'b1;
    repeat (6) tick();
    check("stall_drained", 64'(n_cons - cons0), 64'd3);
    check("stall_queue", 64'(exp_q.size()), 64'd0);

    // Flush with two items in flight; the item offered alongside is refused.
    set_random(4'h1);
    tick();
    set_random(4'h2);
    tick();
    flush_i = 1'b1;
    set_random(4'h3);
    #1 check("flush_in_ready", {63'd0, in_ready_o}, 64'd0);
    tick();
    flush_i = 1'b0;
    set_idle();
    for (int i = 0; i < 4; i++) begin
      check("flush_quiet", {63'd0, out_valid_o}, 64'd0);
      tick();
    end
    run_one("post_flush", 3'd3, 6'd8, 64'h00FF_0000_0000_00AB, 4'hC, 64'hFF00_0000_0000_AB00);

    // Same scenario with a mid-stream reset.
    set_random(4'h4);
    tick();
    set_random(4'h5);
    tick();
    set_idle();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("mid_rst_data", data_o, 64'd0);
    for (int i = 0; i < 4; i++) begin
      check("rst_quiet", {63'd0, out_valid_o}, 64'd0);
      tick();
    end
    run_one("post_rst", 3'd1, 6'd32, 64'hDEAD_BEEF_0000_0000, 4'hD, 64'h0000_0000_DEAD_BEEF);

    // 8-bit, three levels in one stage: single-cycle latency.
    mode8     = 3'd2;
    shift8    = 3'd3;
    data8     = 8'h90;
    tag8      = 4'hA;
    in_valid8 = 1'b1;
    #1 check("w8_ready", {63'd0, in_ready8}, 64'd1);
    @(negedge clk);
    in_valid8 = 1'b0;
    data8     = 'x;
    check("w8_lat1_valid", {63'd0, out_valid8}, 64'd1);
    check("w8_lat1_data", {56'd0, dout8}, 64'h0000_0000_0000_00F2);
    check("w8_lat1_tag", {60'd0, tout8}, 64'hA);
    @(negedge clk);
    check("w8_consumed", {63'd0, out_valid8}, 64'd0);

    // Exhaustive sweep of every mode (including reserved) x shift x data.
    in_valid8 = 1'b1;
    for (int m = 0; m < 8; m++) begin
      for (int sh = 0; sh < 8; sh++) begin
        for (int d = 0; d < 256; d++) begin
          mode8  = 3'(m);
          shift8 = 3'(sh);
          data8  = 8'(d);
          tag8   = 4'(d);
          #1;
          if (out_valid8) check("sweep8", {56'd0, dout8}, {56'd0, q8.pop_front()});
          r64 = ref_shift(8, 3'(m), sh, 64'(d));
          r8  = r64[7:0];
          q8.push_back(r8);
          @(negedge clk);
        end
      end
    end
    in_valid8 = 1'b0;
    #1;
    if (out_valid8) check("sweep8", {56'd0, dout8}, {56'd0, q8.pop_front()});
    check("sweep8_drain", 64'(q8.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
